// File: rtl/acs_pmu4.sv
// acs_pmu4: add-compare-select / path-metric unit for a 4-state (K=3, rate 1/2)
// Viterbi decoder. Each valid symbol updates four path metrics, emits one
// survivor decision per state and reports the minimum-metric state.
// Optional feature macro: ACS_BEST_STATE_EN builds the best-state compare tree;
// without it best_state is tied to 2'b00.
module acs_pmu4 #(
   parameter int PM_W    = 6,
   parameter int INIT_PM = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                init,
   input  logic                bm_valid,
   input  logic [15:0]         bm_in,
   output logic                dec_valid,
   output logic [3:0]          dec,
   output logic [4*PM_W-1:0]   pm_out,
   output logic [1:0]          best_state
);

   // Sums carry one extra bit so overflow can be detected before normalizing.
   localparam int SW = PM_W + 1;
   localparam logic [SW-1:0] HALF_V = SW'(32'd1 << (PM_W - 1));
   localparam logic [SW-1:0] MAX_V  = SW'((32'd1 << PM_W) - 32'd1);
   localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);
   // State 0 starts at zero, the others at the start-up penalty.
   localparam logic [3:0][PM_W-1:0] PM_RESET_V = {INIT_V, INIT_V, INIT_V, {PM_W{1'b0}}};

   logic [3:0][PM_W-1:0] pm_r;
   logic [3:0]           dec_r;
   logic                 dec_valid_r;

   logic [3:0][SW-1:0]   sum0_s;
   logic [3:0][SW-1:0]   sum1_s;
   logic [3:0][SW-1:0]   sel_s;
   logic [3:0][PM_W-1:0] pm_next_s;
   logic [3:0]           dec_next_s;
   logic                 all_high_s;

   // Add-compare-select for every next state, then normalization of the survivors.
   always_comb begin
      sum0_s     = '0;
      sum1_s     = '0;
      sel_s      = '0;
      pm_next_s  = '0;
      dec_next_s = 4'b0000;
      all_high_s = 1'b1;
      for (int ns = 0; ns < 4; ns++) begin
         logic [1:0] nsb;
         nsb = 2'(ns);
         // Predecessors of ns={u,b} are {b,0} and {b,1}.
         sum0_s[ns] = {1'b0, pm_r[{nsb[0], 1'b0}]} + SW'(bm_in[4*ns +: 2]);
         sum1_s[ns] = {1'b0, pm_r[{nsb[0], 1'b1}]} + SW'(bm_in[4*ns+2 +: 2]);
         // Equal sums keep predecessor 0.
         if (sum1_s[ns] < sum0_s[ns]) begin
            sel_s[ns]      = sum1_s[ns];
            dec_next_s[ns] = 1'b1;
         end else begin
            sel_s[ns]      = sum0_s[ns];
            dec_next_s[ns] = 1'b0;
         end
         if (sel_s[ns] < HALF_V) begin
            all_high_s = 1'b0;
         end else begin
            all_high_s = all_high_s;
         end
      end
      for (int ns = 0; ns < 4; ns++) begin
         if (all_high_s) begin
            pm_next_s[ns] = PM_W'(sel_s[ns] - HALF_V);
         end else if (sel_s[ns] > MAX_V) begin
            pm_next_s[ns] = PM_W'(MAX_V);
         end else begin
            pm_next_s[ns] = PM_W'(sel_s[ns]);
         end
      end
   end

   // Path metric, decision and valid registers; init acts as a synchronous reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pm_r        <= PM_RESET_V;
         dec_r       <= 4'b0000;
         dec_valid_r <= 1'b0;
      end else if (init) begin
         pm_r        <= PM_RESET_V;
         dec_r       <= 4'b0000;
         dec_valid_r <= 1'b0;
      end else if (bm_valid) begin
         pm_r        <= pm_next_s;
         dec_r       <= dec_next_s;
         dec_valid_r <= 1'b1;
      end else begin
         dec_valid_r <= 1'b0;
      end
   end

   assign pm_out    = pm_r;
   assign dec       = dec_r;
   assign dec_valid = dec_valid_r;

`ifdef ACS_BEST_STATE_EN
   logic [1:0]      best_r;
   logic [1:0]      best_next_s;
   logic [1:0]      idx01_s;
   logic [1:0]      idx23_s;
   logic [PM_W-1:0] val01_s;
   logic [PM_W-1:0] val23_s;

   // Two-level min tree over the new metrics; ties favour the lower index.
   always_comb begin
      idx01_s     = 2'd0;
      idx23_s     = 2'd2;
      val01_s     = pm_next_s[0];
      val23_s     = pm_next_s[2];
      best_next_s = 2'd0;
      if (pm_next_s[1] < pm_next_s[0]) begin
         idx01_s = 2'd1;
         val01_s = pm_next_s[1];
      end else begin
         idx01_s = 2'd0;
         val01_s = pm_next_s[0];
      end
      if (pm_next_s[3] < pm_next_s[2]) begin
         idx23_s = 2'd3;
         val23_s = pm_next_s[3];
      end else begin
         idx23_s = 2'd2;
         val23_s = pm_next_s[2];
      end
      if (val23_s < val01_s) begin
         best_next_s = idx23_s;
      end else begin
         best_next_s = idx01_s;
      end
   end

   // Best-state register follows the metric register's load conditions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_r <= 2'd0;
      end else if (init) begin
         best_r <= 2'd0;
      end else if (bm_valid) begin
         best_r <= best_next_s;
      end else begin
         best_r <= best_r;
      end
   end

   assign best_state = best_r;
`else
   assign best_state = 2'b00;
`endif

endmodule

// File: tb/tb_acs_pmu4.sv
// Self-checking bench for acs_pmu4: a reference model pushes expected symbol
// results to a scoreboard when stimulus is driven; a monitor pops and compares
// whenever dec_valid is seen. Scenario tasks add direct checks.
module tb_acs_pmu4;
   localparam int PM_W    = 6;
   localparam int INIT_PM = 16;
   localparam int HALF    = 1 << (PM_W - 1);
   localparam int MAXV    = (1 << PM_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              init;
   logic              bm_valid;
   logic [15:0]       bm_in;
   logic              dec_valid;
   logic [3:0]        dec;
   logic [4*PM_W-1:0] pm_out;
   logic [1:0]        best_state;

   typedef struct packed {
      logic [4*PM_W-1:0] pm;
      logic [3:0]        dec;
      logic [1:0]        best;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         mpm[4];
   logic [3:0] mdec;
   logic [1:0] mbest;

   acs_pmu4 #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
      .clk(clk), .rst(rst), .init(init), .bm_valid(bm_valid), .bm_in(bm_in),
      .dec_valid(dec_valid), .dec(dec), .pm_out(pm_out), .best_state(best_state)
   );

   always #5 clk = ~clk;

   function automatic logic [4*PM_W-1:0] pack_pm(input int a0, input int a1, input int a2, input int a3);
      logic [4*PM_W-1:0] r;
      r[0*PM_W +: PM_W] = PM_W'(a0);
      r[1*PM_W +: PM_W] = PM_W'(a1);
      r[2*PM_W +: PM_W] = PM_W'(a2);
      r[3*PM_W +: PM_W] = PM_W'(a3);
      return r;
   endfunction

   function automatic logic [1:0] exp_best();
`ifdef ACS_BEST_STATE_EN
      return mbest;
`else
      return 2'b00;
`endif
   endfunction

   function automatic void model_reset();
      mpm[0] = 0; mpm[1] = INIT_PM; mpm[2] = INIT_PM; mpm[3] = INIT_PM;
      mdec = 4'b0000;
      mbest = 2'd0;
   endfunction

   function automatic void model_step(input logic [15:0] b);
      int s[4];
      int c0, c1, pb;
      bit allh;
      allh = 1'b1;
      for (int ns = 0; ns < 4; ns++) begin
         pb = (ns % 2) * 2;
         c0 = mpm[pb] + int'(b[4*ns +: 2]);
         c1 = mpm[pb+1] + int'(b[4*ns+2 +: 2]);
         if (c1 < c0) begin s[ns] = c1; mdec[ns] = 1'b1; end
         else begin s[ns] = c0; mdec[ns] = 1'b0; end
         if (s[ns] < HALF) allh = 1'b0;
      end
      for (int ns = 0; ns < 4; ns++) begin
         if (allh) mpm[ns] = s[ns] - HALF;
         else if (s[ns] > MAXV) mpm[ns] = MAXV;
         else mpm[ns] = s[ns];
      end
      mbest = 2'd0;
      for (int ns = 1; ns < 4; ns++)
         if (mpm[ns] < mpm[mbest]) mbest = 2'(ns);
   endfunction

   // Scoreboard monitor: every dec_valid pulse must match the oldest expected symbol.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && dec_valid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: dec_valid=1 got, required 0 (no symbol pending)");
         end else begin
            e = sb.pop_front();
            if (pm_out !== e.pm || dec !== e.dec || best_state !== e.best) begin
               n_bad++;
               $display("FAIL sb_symbol: got pm=%h dec=%b best=%0d, required pm=%h dec=%b best=%0d",
                        pm_out, dec, best_state, e.pm, e.dec, e.best);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [15:0] b, input logic ini);
      exp_t e;
      bm_valid = v; bm_in = b; init = ini;
      if (ini) model_reset();
      else if (v) begin
         model_step(b);
         e.pm = pack_pm(mpm[0], mpm[1], mpm[2], mpm[3]);
         e.dec = mdec;
         e.best = exp_best();
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bm_valid = 1'b0; init = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; init = 1'b0; bm_valid = 1'b0; bm_in = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_cmp++; if (pm_out !== pack_pm(0, 16, 16, 16)) begin n_bad++; $display("FAIL reset_pm: got %h required %h", pm_out, pack_pm(0, 16, 16, 16)); end
      n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dec_valid: got %b required 0", dec_valid); end
      n_cmp++; if (dec !== 4'b0000) begin n_bad++; $display("FAIL reset_dec: got %b required 0000", dec); end
      n_cmp++; if (best_state !== 2'd0) begin n_bad++; $display("FAIL reset_best: got %0d required 0", best_state); end
   endtask

   task automatic test_zero_bm();
      drive(1'b1, 16'h0000, 1'b0);
      n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL zero_dec_valid: got %b required 1", dec_valid); end
      n_cmp++; if (pm_out !== pack_pm(0, 16, 0, 16)) begin n_bad++; $display("FAIL zero_pm: got %h required %h", pm_out, pack_pm(0, 16, 0, 16)); end
      n_cmp++; if (dec !== 4'b0000) begin n_bad++; $display("FAIL zero_dec: got %b required 0000", dec); end
      n_cmp++; if (best_state !== 2'd0) begin n_bad++; $display("FAIL zero_best: got %0d required 0", best_state); end
   endtask

   task automatic test_select_p1();
      do_reset();
      drive(1'b1, 16'h3333, 1'b0);
      n_cmp++; if (pm_out !== pack_pm(3, 16, 3, 16)) begin n_bad++; $display("FAIL sel_pm: got %h required %h", pm_out, pack_pm(3, 16, 3, 16)); end
      n_cmp++; if (dec !== 4'b1010) begin n_bad++; $display("FAIL sel_dec: got %b required 1010", dec); end
   endtask

   task automatic test_normalize();
      do_reset();
      for (int i = 1; i <= 11; i++) begin
         drive(1'b1, 16'hFFFF, 1'b0);
         n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL norm_dec_valid[%0d]: got %b required 1", i, dec_valid); end
         if (i == 10) begin
            n_cmp++; if (pm_out !== pack_pm(30, 30, 30, 30)) begin n_bad++; $display("FAIL norm_pre: got %h required %h", pm_out, pack_pm(30, 30, 30, 30)); end
         end
         if (i == 11) begin
            n_cmp++; if (pm_out !== pack_pm(1, 1, 1, 1)) begin n_bad++; $display("FAIL norm_post: got %h required %h", pm_out, pack_pm(1, 1, 1, 1)); end
         end
      end
   endtask

   task automatic test_init_collision();
      do_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, 16'($urandom), 1'b0);
      drive(1'b1, 16'($urandom), 1'b1);
      n_cmp++; if (pm_out !== pack_pm(0, 16, 16, 16)) begin n_bad++; $display("FAIL init_pm: got %h required %h", pm_out, pack_pm(0, 16, 16, 16)); end
      n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL init_dec_valid: got %b required 0", dec_valid); end
      n_cmp++; if (dec !== 4'b0000) begin n_bad++; $display("FAIL init_dec: got %b required 0000", dec); end
      drive(1'b1, 16'h3C96, 1'b0);
      n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL init_next_valid: got %b required 1", dec_valid); end
   endtask

   task automatic test_hold_and_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 16'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 16'($urandom), 1'b0);
         n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL hold_dec_valid[%0d]: got %b required 0", i, dec_valid); end
         n_cmp++; if (pm_out !== pack_pm(mpm[0], mpm[1], mpm[2], mpm[3]) || dec !== mdec || best_state !== exp_best()) begin
            n_bad++;
            $display("FAIL hold_state[%0d]: got pm=%h dec=%b best=%0d required pm=%h dec=%b best=%0d", i,
                     pm_out, dec, best_state, pack_pm(mpm[0], mpm[1], mpm[2], mpm[3]), mdec, exp_best());
         end
      end
      // Mid-cycle asynchronous reset: outputs must clear before the next clock edge.
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (pm_out !== pack_pm(0, 16, 16, 16) || dec !== 4'b0000 || dec_valid !== 1'b0 || best_state !== 2'd0) begin
         n_bad++;
         $display("FAIL async_rst: got pm=%h dec=%b dv=%b best=%0d required pm=%h dec=0000 dv=0 best=0",
                  pm_out, dec, dec_valid, best_state, pack_pm(0, 16, 16, 16));
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 80; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 5) drive(1'b1, 16'($urandom), 1'b1);
         else if (r < 75) drive(1'b1, 16'($urandom), 1'b0);
         else drive(1'b0, 16'($urandom), 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_zero_bm();
      test_select_p1();
      test_normalize();
      test_init_collision();
      test_hold_and_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
